// File: rtl/calc_req_issuer_if.sv
`default_nettype none
// ============================================================================
//  Module      : calc_req_issuer_if
//  Description : Producer, calculator request/response and result signals
//                for the calc_req_issuer stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface calc_req_issuer_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_cmd;
    logic [DATA_W-1:0] in_op1;
    logic [DATA_W-1:0] in_op2;

    logic [3:0]        req_cmd_out;
    logic [DATA_W-1:0] req_data_out;
    logic [TAG_W-1:0]  req_tag_out;

    logic [1:0]        out_resp;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;

    logic              res_valid;
    logic [1:0]        res_resp;
    logic [DATA_W-1:0] res_data;
    logic [TAG_W-1:0]  res_tag;
    logic [TAG_W:0]    outstanding;
    logic              err_spurious;

    // Issuer side
    modport slave (
        input  in_valid, in_cmd, in_op1, in_op2,
        input  out_resp, out_data, out_tag,
        output in_ready,
        output req_cmd_out, req_data_out, req_tag_out,
        output res_valid, res_resp, res_data, res_tag,
        output outstanding, err_spurious
    );

    // Environment side: producer, calculator and result consumer
    modport master (
        output in_valid, in_cmd, in_op1, in_op2,
        output out_resp, out_data, out_tag,
        input  in_ready,
        input  req_cmd_out, req_data_out, req_tag_out,
        input  res_valid, res_resp, res_data, res_tag,
        input  outstanding, err_spurious
    );
endinterface
`default_nettype wire

// File: rtl/calc_req_issuer.sv
`default_nettype none
// ============================================================================
//  Module      : calc_req_issuer
//  Description : Buffers commands, issues them as two-cycle tagged requests,
//                tracks outstanding tags and registers returned responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module calc_req_issuer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    calc_req_issuer_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int NTAGS = 1 << TAG_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OP1  = 2'd1,
        S_OP2  = 2'd2
    } state_t;

    logic [3:0]        fifo_cmd [DEPTH];
    logic [DATA_W-1:0] fifo_op1 [DEPTH];
    logic [DATA_W-1:0] fifo_op2 [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    state_t            state_q, state_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [DATA_W-1:0] op2_q, op2_d;
    logic [NTAGS-1:0]  busy_q, busy_d;
    logic [TAG_W:0]    outstanding_q, outstanding_d;
    logic [3:0]        req_cmd_q, req_cmd_d;
    logic [DATA_W-1:0] req_data_q, req_data_d;
    logic [TAG_W-1:0]  req_tag_q, req_tag_d;
    logic              res_valid_q, res_valid_d;
    logic [1:0]        res_resp_q, res_resp_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic [TAG_W-1:0]  res_tag_q, res_tag_d;
    logic              err_q, err_d;

    logic              w_in_ready;
    logic              w_push;
    logic              w_pop;
    logic              w_free_any;
    logic [TAG_W-1:0]  w_free_tag;
    logic              w_can_issue;

    assign w_in_ready  = reset_n && (count_q < CNT_W'(DEPTH));
    // Zero opcodes complete the handshake but never enter the FIFO
    assign w_push      = bus.in_valid && w_in_ready && (bus.in_cmd != 4'd0);
    assign w_can_issue = (count_q != '0) && w_free_any;

    // Lowest-index free tag, taken from the pre-update busy vector
    always_comb begin
        w_free_any = 1'b0;
        w_free_tag = '0;
        for (int i = NTAGS - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                w_free_any = 1'b1;
                w_free_tag = i[TAG_W-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        tag_d      = tag_q;
        op2_d      = op2_q;
        req_cmd_d  = 4'd0;
        req_data_d = '0;
        req_tag_d  = '0;
        w_pop      = 1'b0;

        case (state_q)
            S_OP1: begin
                state_d    = S_OP2;
                req_data_d = op2_q;
            end
            S_IDLE, S_OP2: begin
                if (w_can_issue) begin
                    state_d    = S_OP1;
                    w_pop      = 1'b1;
                    tag_d      = w_free_tag;
                    op2_d      = fifo_op2[rd_ptr_q];
                    req_cmd_d  = fifo_cmd[rd_ptr_q];
                    req_data_d = fifo_op1[rd_ptr_q];
                    req_tag_d  = w_free_tag;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(w_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(w_pop);
        count_d  = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
    end

    always_comb begin
        busy_d      = busy_q;
        err_d       = err_q;
        res_valid_d = (bus.out_resp != 2'd0);
        res_resp_d  = res_resp_q;
        res_data_d  = res_data_q;
        res_tag_d   = res_tag_q;

        if (bus.out_resp != 2'd0) begin
            res_resp_d = bus.out_resp;
            res_data_d = bus.out_data;
            res_tag_d  = bus.out_tag;
            if (busy_q[bus.out_tag]) begin
                busy_d[bus.out_tag] = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
        // Allocation is committed at the end of the OP1 cycle
        if (state_q == S_OP1) begin
            busy_d[tag_q] = 1'b1;
        end

        outstanding_d = '0;
        for (int i = 0; i < NTAGS; i++) begin
            outstanding_d = outstanding_d + (TAG_W+1)'(busy_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_cmd[wr_ptr_q] <= bus.in_cmd;
            fifo_op1[wr_ptr_q] <= bus.in_op1;
            fifo_op2[wr_ptr_q] <= bus.in_op2;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= S_IDLE;
            tag_q         <= '0;
            op2_q         <= '0;
            busy_q        <= '0;
            outstanding_q <= '0;
            req_cmd_q     <= 4'd0;
            req_data_q    <= '0;
            req_tag_q     <= '0;
            res_valid_q   <= 1'b0;
            res_resp_q    <= 2'd0;
            res_data_q    <= '0;
            res_tag_q     <= '0;
            err_q         <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            tag_q         <= tag_d;
            op2_q         <= op2_d;
            busy_q        <= busy_d;
            outstanding_q <= outstanding_d;
            req_cmd_q     <= req_cmd_d;
            req_data_q    <= req_data_d;
            req_tag_q     <= req_tag_d;
            res_valid_q   <= res_valid_d;
            res_resp_q    <= res_resp_d;
            res_data_q    <= res_data_d;
            res_tag_q     <= res_tag_d;
            err_q         <= err_d;
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.req_cmd_out  = req_cmd_q;
    assign bus.req_data_out = req_data_q;
    assign bus.req_tag_out  = req_tag_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_resp     = res_resp_q;
    assign bus.res_data     = res_data_q;
    assign bus.res_tag      = res_tag_q;
    assign bus.outstanding  = outstanding_q;
    assign bus.err_spurious = err_q;
endmodule
`default_nettype wire

// File: tb/tb_calc_req_issuer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_calc_req_issuer
//  Description : Scoreboard testbench for calc_req_issuer.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_calc_req_issuer;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 2;

    typedef struct {
        logic [3:0]        cmd;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
    } req_t;

    typedef struct {
        logic [1:0]        resp;
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } res_t;

    logic clk;
    logic reset_n;

    calc_req_issuer_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    calc_req_issuer #(.DEPTH(4), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    req_t              exp_req [$];
    res_t              exp_res [$];
    int                op1_cyc [$];
    logic [3:0]        mbusy     = 4'b0000;
    logic              exp_err   = 1'b0;
    logic              expect_op2 = 1'b0;
    logic [DATA_W-1:0] exp_op2   = '0;
    logic [TAG_W-1:0]  last_tag  = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [TAG_W-1:0] lowest_free(input logic [3:0] b);
        logic [TAG_W-1:0] t;
        t = '0;
        for (int i = 3; i >= 0; i--) if (!b[i]) t = i[TAG_W-1:0];
        return t;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        req_t e;
        res_t r;
        if (!reset_n) begin
            exp_req.delete();
            mbusy      = 4'b0000;
            exp_err    = 1'b0;
            expect_op2 = 1'b0;
        end else begin
            if (expect_op2) begin
                check("op2_cmd", 64'(bus.req_cmd_out), 64'd0);
                check("op2_data", 64'(bus.req_data_out), 64'(exp_op2));
                check("op2_tag", 64'(bus.req_tag_out), 64'd0);
                expect_op2 = 1'b0;
            end else if (bus.req_cmd_out != 4'd0) begin
                if (exp_req.size() == 0) begin
                    check("unexpected_req", 64'(bus.req_cmd_out), 64'd0);
                end else begin
                    e = exp_req.pop_front();
                    check("op1_cmd", 64'(bus.req_cmd_out), 64'(e.cmd));
                    check("op1_data", 64'(bus.req_data_out), 64'(e.op1));
                    check("op1_tag", 64'(bus.req_tag_out), 64'(lowest_free(mbusy)));
                    mbusy[bus.req_tag_out] = 1'b1;
                    last_tag   = bus.req_tag_out;
                    exp_op2    = e.op2;
                    expect_op2 = 1'b1;
                    op1_cyc.push_back(cyc);
                end
            end else begin
                check("idle_req", {30'd0, bus.req_data_out, bus.req_tag_out}, 64'd0);
            end

            if (bus.res_valid) begin
                if (exp_res.size() == 0) begin
                    check("unexpected_res", 64'(bus.res_valid), 64'd0);
                end else begin
                    r = exp_res.pop_front();
                    check("res_resp", 64'(bus.res_resp), 64'(r.resp));
                    check("res_data", 64'(bus.res_data), 64'(r.data));
                    check("res_tag", 64'(bus.res_tag), 64'(r.tag));
                    if (!mbusy[bus.res_tag]) exp_err = 1'b1;
                    else mbusy[bus.res_tag] = 1'b0;
                    check("err_spurious", 64'(bus.err_spurious), 64'(exp_err));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] cmd, input logic [DATA_W-1:0] a,
                        input logic [DATA_W-1:0] b, output int acc_cyc);
        req_t e;
        int   waited;
        bus.in_valid = 1'b1;
        bus.in_cmd   = cmd;
        bus.in_op1   = a;
        bus.in_op2   = b;
        waited = 0;
        while (!bus.in_ready && waited < 200) begin
            tick();
            waited++;
        end
        if (!bus.in_ready) check("push_timeout", 64'(bus.in_ready), 64'd1);
        if (cmd != 4'd0) begin
            e.cmd = cmd; e.op1 = a; e.op2 = b;
            exp_req.push_back(e);
        end
        acc_cyc = cyc;
        tick();
        bus.in_valid = 1'b0;
        bus.in_cmd   = 4'd0;
    endtask

    task automatic respond(input logic [1:0] resp, input logic [TAG_W-1:0] tag,
                           input logic [DATA_W-1:0] data);
        res_t r;
        r.resp = resp; r.data = data; r.tag = tag;
        exp_res.push_back(r);
        bus.out_resp = resp;
        bus.out_tag  = tag;
        bus.out_data = data;
        tick();
        bus.out_resp = 2'd0;
    endtask

    task automatic wait_op1(input string tag, input int n0);
        int k;
        k = 0;
        while (op1_cyc.size() <= n0 && k < 60) begin
            tick();
            k++;
        end
        if (op1_cyc.size() <= n0) check(tag, 64'(op1_cyc.size()), 64'(n0 + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        int n0;
        logic [TAG_W-1:0] t;

        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_cmd   = 4'd0;
        bus.in_op1   = '0;
        bus.in_op2   = '0;
        bus.out_resp = 2'd0;
        bus.out_data = '0;
        bus.out_tag  = '0;
        repeat (3) tick();

        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_req", {28'd0, bus.req_cmd_out, bus.req_data_out}, 64'd0);
        check("rst_res_valid", 64'(bus.res_valid), 64'd0);
        check("rst_outstanding", 64'(bus.outstanding), 64'd0);
        check("rst_err", 64'(bus.err_spurious), 64'd0);
        reset_n = 1'b1;
        tick();
        check("ready_after_rst", 64'(bus.in_ready), 64'd1);

        // Single command: latency, tag 0, outstanding after OP1
        n0 = op1_cyc.size();
        push(4'd1, 32'd5, 32'd3, acc);
        wait_op1("timeout_first_op1", n0);
        check("first_latency", 64'(op1_cyc[n0] - acc), 64'd2);
        check("first_tag", 64'(last_tag), 64'd0);
        tick();
        check("outstanding_one", 64'(bus.outstanding), 64'd1);
        respond(2'd1, 2'd0, 32'd8);
        repeat (3) tick();
        check("outstanding_zero", 64'(bus.outstanding), 64'd0);

        // Eight commands: four issue back-to-back, four fill the FIFO
        n0 = op1_cyc.size();
        for (int i = 0; i < 8; i++) push(4'(1 + i), $urandom, $urandom, acc);
        for (int k = 0; k < 50 && bus.outstanding != 3'd4; k++) tick();
        repeat (3) tick();
        check("full_outstanding", 64'(bus.outstanding), 64'd4);
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        check("full_issued", 64'(op1_cyc.size() - n0), 64'd4);
        for (int i = 1; i < 4; i++)
            check("b2b_gap", 64'(op1_cyc[n0 + i] - op1_cyc[n0 + i - 1]), 64'd2);

        n0 = op1_cyc.size();
        respond(2'd1, 2'd2, 32'd8);
        wait_op1("timeout_reuse2", n0);
        check("reuse_tag2", 64'(last_tag), 64'd2);
        n0 = op1_cyc.size();
        respond(2'd2, 2'd0, 32'hDEAD_BEEF);
        wait_op1("timeout_reuse0", n0);
        check("reuse_tag0", 64'(last_tag), 64'd0);
        tick();
        check("ready_after_two", 64'(bus.in_ready), 64'd1);

        // Drain everything still queued or in flight
        for (int k = 0; k < 60 && (exp_req.size() != 0 || mbusy != 4'b0000 || expect_op2); k++) begin
            if (mbusy != 4'b0000) begin
                t = lowest_free(~mbusy);
                respond(2'd3, t, 32'(k));
            end
            repeat (3) tick();
        end
        check("drain_req", 64'(exp_req.size()), 64'd0);
        check("drain_outstanding", 64'(bus.outstanding), 64'd0);

        // Spurious response with nothing in flight
        respond(2'd1, 2'd1, 32'h55);
        repeat (3) tick();
        check("spurious_sticky", 64'(bus.err_spurious), 64'd1);
        check("spurious_outstanding", 64'(bus.outstanding), 64'd0);

        // Reset during an OP1 cycle, with another command still queued
        n0 = op1_cyc.size();
        push(4'd3, 32'd11, 32'd12, acc);
        push(4'd4, 32'd13, 32'd14, acc);
        for (int k = 0; k < 20 && bus.req_cmd_out == 4'd0; k++) tick();
        check("op1_before_reset", 64'(bus.req_cmd_out != 4'd0), 64'd1);
        reset_n = 1'b0;
        tick();
        check("midrst_req", {28'd0, bus.req_cmd_out, bus.req_data_out}, 64'd0);
        check("midrst_tag", 64'(bus.req_tag_out), 64'd0);
        check("midrst_outstanding", 64'(bus.outstanding), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        check("midrst_err", 64'(bus.err_spurious), 64'd0);
        tick();
        reset_n = 1'b1;
        #1;
        check("postrst_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (8) tick();
        check("postrst_outstanding", 64'(bus.outstanding), 64'd0);

        // Zero opcode is accepted and dropped; the next real command gets tag 0
        n0 = op1_cyc.size();
        push(4'd0, 32'd77, 32'd78, acc);
        repeat (6) tick();
        check("noop_not_issued", 64'(op1_cyc.size() - n0), 64'd0);
        check("noop_in_ready", 64'(bus.in_ready), 64'd1);
        push(4'd9, 32'd21, 32'd22, acc);
        wait_op1("timeout_after_noop", n0);
        check("after_noop_latency", 64'(op1_cyc[n0] - acc), 64'd2);
        check("after_noop_tag", 64'(last_tag), 64'd0);
        tick();
        respond(2'd1, 2'd0, 32'd43);
        repeat (4) tick();

        check("end_req_queue", 64'(exp_req.size()), 64'd0);
        check("end_res_queue", 64'(exp_res.size()), 64'd0);
        check("end_outstanding", 64'(bus.outstanding), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
